// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types and constants for the milano core
package milano_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_NOP = 2'd3
  } alu_opt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // Source operand selection: x0 reads zero, a matching ALU write wins over the register file.
  function automatic logic [31:0] fwd_value(input logic [4:0]  addr,
                                            input logic [31:0] rf_data,
                                            input logic        wb_we,
                                            input logic [4:0]  wb_addr,
                                            input logic [31:0] wb_data);
    if (addr == 5'd0)
      return 32'd0;
    else if (wb_we && (wb_addr == addr))
      return wb_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/milano_decoder.sv
// rtl/milano_decoder.sv - combinational ADD/SUB/ADDI decoder
module milano_decoder
  import milano_pkg::*;
(
  input  logic [31:0] instr,
  output alu_opt_e    operator,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        illegal,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr  = instr[11:7];
  assign imm      = {{20{instr[31]}}, instr[31:20]};

  // Opcode/funct decode; anything unrecognised is flagged illegal and maps to NOP.
  always_comb begin
    operator = ALU_NOP;
    use_imm  = 1'b0;
    illegal  = 1'b1;
    if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == F7_ADD) begin
      operator = ALU_ADD;
      illegal  = 1'b0;
    end else if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == F7_SUB) begin
      operator = ALU_SUB;
      illegal  = 1'b0;
    end else if (opcode == OPC_OP_IMM && funct3 == 3'b000) begin
      operator = ALU_ADD;
      use_imm  = 1'b1;
      illegal  = 1'b0;
    end
  end

endmodule

// File: rtl/milano_id_stage.sv
// rtl/milano_id_stage.sv - decode stage with forwarding and ID/EX register
module milano_id_stage
  import milano_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        flush_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output alu_opt_e    operator_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic [31:0] rd_addr_o,
  output logic        illegal_instr_o
);

  alu_opt_e    dec_operator;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic [4:0]  dec_rd;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        accept;

  milano_decoder u_decoder (
    .instr    (instr_i),
    .operator (dec_operator),
    .use_imm  (dec_use_imm),
    .imm      (dec_imm),
    .illegal  (dec_illegal),
    .rs1_addr (rs1_addr_o),
    .rs2_addr (rs2_addr_o),
    .rd_addr  (dec_rd)
  );

  // Reset behaves like a held flush so nothing is accepted until it is released.
  assign instr_ready_o = rst_ni && !flush_i && (!ex_valid_o || ex_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  assign src_a = fwd_value(rs1_addr_o, rs1_data_i, wb_we_i, wb_addr_i, wb_data_i);
  assign src_b = dec_use_imm ? dec_imm
                             : fwd_value(rs2_addr_o, rs2_data_i, wb_we_i, wb_addr_i, wb_data_i);

  // ID/EX register: flush clears, legal accept loads, illegal accept or drain clears, stall holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o      <= 1'b0;
      operator_o      <= ALU_NOP;
      operand_a_o     <= 32'd0;
      operand_b_o     <= 32'd0;
      rd_addr_o       <= 32'd0;
      illegal_instr_o <= 1'b0;
    end else begin
      illegal_instr_o <= accept && dec_illegal;
      if (accept && !dec_illegal) begin
        ex_valid_o  <= 1'b1;
        operator_o  <= dec_operator;
        operand_a_o <= src_a;
        operand_b_o <= src_b;
        rd_addr_o   <= {27'd0, dec_rd};
      end else if (flush_i || accept || ex_ready_i) begin
        ex_valid_o  <= 1'b0;
        operator_o  <= ALU_NOP;
        operand_a_o <= 32'd0;
        operand_b_o <= 32'd0;
        rd_addr_o   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_milano_id_stage.sv
// tb/tb_milano_id_stage.sv - directed self-checking bench for milano_id_stage
module tb_milano_id_stage;
  import milano_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  alu_opt_e    operator_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic [31:0] rd_addr_o;
  logic        illegal_instr_o;

  int n_checks = 0;
  int n_fails  = 0;

  milano_id_stage dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .instr_i         (instr_i),
    .instr_valid_i   (instr_valid_i),
    .instr_ready_o   (instr_ready_o),
    .flush_i         (flush_i),
    .rs1_addr_o      (rs1_addr_o),
    .rs2_addr_o      (rs2_addr_o),
    .rs1_data_i      (rs1_data_i),
    .rs2_data_i      (rs2_data_i),
    .wb_we_i         (wb_we_i),
    .wb_addr_i       (wb_addr_i),
    .wb_data_i       (wb_data_i),
    .ex_valid_o      (ex_valid_o),
    .ex_ready_i      (ex_ready_i),
    .operator_o      (operator_o),
    .operand_a_o     (operand_a_o),
    .operand_b_o     (operand_b_o),
    .rd_addr_o       (rd_addr_o),
    .illegal_instr_o (illegal_instr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_ex(input string tag, input logic v, input alu_opt_e op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
    check({tag, ".valid"}, {31'd0, ex_valid_o}, {31'd0, v});
    check({tag, ".op"}, {30'd0, operator_o}, {30'd0, op});
    check({tag, ".a"}, operand_a_o, a);
    check({tag, ".b"}, operand_b_o, b);
    check({tag, ".rd"}, rd_addr_o, rd);
  endtask

  initial begin
    rst_ni = 1'b0; instr_i = 32'd0; instr_valid_i = 1'b0; flush_i = 1'b0;
    rs1_data_i = 32'd0; rs2_data_i = 32'd0; wb_we_i = 1'b0; wb_addr_i = 5'd0;
    wb_data_i = 32'd0; ex_ready_i = 1'b1;
    tick(); tick();
    instr_valid_i = 1'b1; instr_i = 32'h002081B3;
    #1;
    check("rst.ready", {31'd0, instr_ready_o}, 32'd0);
    check_ex("rst", 1'b0, ALU_NOP, 32'd0, 32'd0, 32'd0);
    check("rst.illegal", {31'd0, illegal_instr_o}, 32'd0);
    tick();
    check("rst.noaccept", {31'd0, ex_valid_o}, 32'd0);
    rst_ni = 1'b1;

    // ADD x3,x1,x2
    rs1_data_i = 32'd5; rs2_data_i = 32'd7;
    #1;
    check("add.ready", {31'd0, instr_ready_o}, 32'd1);
    check("add.rs1", {27'd0, rs1_addr_o}, 32'd1);
    check("add.rs2", {27'd0, rs2_addr_o}, 32'd2);
    tick();
    check_ex("add", 1'b1, ALU_ADD, 32'd5, 32'd7, 32'd3);

    // ADDI x4,x0,-1 : x0 reads zero even with nonzero register-file data
    instr_i = 32'hFFF00213;
    tick();
    check_ex("addi", 1'b1, ALU_ADD, 32'd0, 32'hFFFFFFFF, 32'd4);

    // SUB x5,x3,x3 with x3 forwarded from writeback
    instr_i = 32'h403182B3; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    wb_we_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'd12;
    tick();
    check_ex("sub_fwd", 1'b1, ALU_SUB, 32'd12, 32'd12, 32'd5);

    // SUB x5,x0,x0 with writeback to x0: both sources zero
    instr_i = 32'h400002B3; wb_addr_i = 5'd0; rs1_data_i = 32'd9; rs2_data_i = 32'd9;
    tick();
    check_ex("sub_x0", 1'b1, ALU_SUB, 32'd0, 32'd0, 32'd5);

    // SUB x5,x3,x3 with writeback to another register: register file used
    instr_i = 32'h403182B3; rs2_data_i = 32'd4;
    tick();
    check_ex("sub_nofwd", 1'b1, ALU_SUB, 32'd9, 32'd4, 32'd5);

    // Stall three cycles with a new ADD x6,x1,x2 waiting
    wb_we_i = 1'b0; ex_ready_i = 1'b0;
    instr_i = 32'h00208333; rs1_data_i = 32'd20; rs2_data_i = 32'd22;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.ready", {31'd0, instr_ready_o}, 32'd0);
      tick();
      check_ex("stall", 1'b1, ALU_SUB, 32'd9, 32'd4, 32'd5);
    end
    ex_ready_i = 1'b1;
    #1;
    check("unstall.ready", {31'd0, instr_ready_o}, 32'd1);
    tick();
    check_ex("unstall", 1'b1, ALU_ADD, 32'd20, 32'd22, 32'd6);

    // Illegal all-zero word
    instr_i = 32'h00000000;
    tick();
    check("ill.pulse", {31'd0, illegal_instr_o}, 32'd1);
    check_ex("ill", 1'b0, ALU_NOP, 32'd0, 32'd0, 32'd0);
    instr_valid_i = 1'b0;
    tick();
    check("ill.end", {31'd0, illegal_instr_o}, 32'd0);

    // Drain: accept ADD, then no input with downstream ready clears EX
    instr_valid_i = 1'b1; instr_i = 32'h002081B3; rs1_data_i = 32'd1; rs2_data_i = 32'd2;
    tick();
    check_ex("load", 1'b1, ALU_ADD, 32'd1, 32'd2, 32'd3);
    instr_valid_i = 1'b0;
    tick();
    check_ex("drain", 1'b0, ALU_NOP, 32'd0, 32'd0, 32'd0);

    // Flush over a live entry while an illegal word is offered
    instr_valid_i = 1'b1; instr_i = 32'h002081B3;
    tick();
    check("preflush.valid", {31'd0, ex_valid_o}, 32'd1);
    flush_i = 1'b1; ex_ready_i = 1'b1; instr_i = 32'h00000000;
    #1;
    check("flush.ready", {31'd0, instr_ready_o}, 32'd0);
    tick();
    check_ex("flush", 1'b0, ALU_NOP, 32'd0, 32'd0, 32'd0);
    check("flush.illegal", {31'd0, illegal_instr_o}, 32'd0);
    flush_i = 1'b0;

    // Reset asserted mid-stall clears asynchronously
    instr_i = 32'h002081B3;
    tick();
    check("prerst.valid", {31'd0, ex_valid_o}, 32'd1);
    ex_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_ex("async_rst", 1'b0, ALU_NOP, 32'd0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
